// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - two-master round-robin bus arbiter with registered one-hot grants and select mux
module ahb_arbiter (
   input  logic       hclk,
   input  logic       hresetn,
   input  logic       hreq_1,
   input  logic       hreq_2,
   input  logic [1:0] sel_1,
   input  logic [1:0] sel_2,
   input  logic       hready,
   input  logic       hready_out,
   input  logic       hresp,
   output logic       hgrant_1,
   output logic       hgrant_2,
   output logic [1:0] sel
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT1 = 2'b01,
      GNT2 = 2'b10
   } state_t;

   // last_owner: 0 = master 1, 1 = master 2
   state_t     state_q, state_d;
   logic       last_owner_q, last_owner_d;
   logic [1:0] sel_q, sel_d;
   logic       boundary;

   assign boundary = hready | hready_out;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (hreq_1 && hreq_2) begin
               state_d = last_owner_q ? GNT1 : GNT2;
            end else if (hreq_1) begin
               state_d = GNT1;
            end else if (hreq_2) begin
               state_d = GNT2;
            end
         end
         GNT1: begin
            // a pending request from the other master beats an error release
            if (boundary) begin
               if (hreq_2) begin
                  state_d = GNT2;
               end else if (hresp || !hreq_1) begin
                  state_d = IDLE;
               end
            end
         end
         GNT2: begin
            if (boundary) begin
               if (hreq_1) begin
                  state_d = GNT1;
               end else if (hresp || !hreq_2) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_owner_d = last_owner_q;
      sel_d        = 2'b00;
      case (state_d)
         GNT1: begin
            last_owner_d = 1'b0;
            sel_d        = sel_1;
         end
         GNT2: begin
            last_owner_d = 1'b1;
            sel_d        = sel_2;
         end
         default: begin
            last_owner_d = last_owner_q;
            sel_d        = 2'b00;
         end
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hresetn) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         sel_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         sel_q        <= sel_d;
      end
   end

   assign hgrant_1 = (state_q == GNT1);
   assign hgrant_2 = (state_q == GNT2);
   assign sel      = sel_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - randomized and directed checks of ahb_arbiter against a behavioural model
module tb_ahb_arbiter;

   logic       hclk = 1'b0;
   logic       hresetn, hreq_1, hreq_2, hready, hready_out, hresp;
   logic [1:0] sel_1, sel_2;
   logic       hgrant_1, hgrant_2;
   logic [1:0] sel;

   int vectors = 0;
   int miscompares = 0;

   // model: owner 0 = nobody, 1 = master 1, 2 = master 2
   int       m_owner = 0;
   int       m_last = 2;
   logic [1:0] m_sel = 2'b00;

   always #5 hclk = ~hclk;

   ahb_arbiter dut (
      .hclk(hclk), .hresetn(hresetn),
      .hreq_1(hreq_1), .hreq_2(hreq_2),
      .sel_1(sel_1), .sel_2(sel_2),
      .hready(hready), .hready_out(hready_out), .hresp(hresp),
      .hgrant_1(hgrant_1), .hgrant_2(hgrant_2), .sel(sel)
   );

   function automatic bit wants(int m);
      return (m == 1) ? hreq_1 : hreq_2;
   endfunction

   task automatic model_edge();
      int nxt;
      nxt = m_owner;
      if (hresetn) begin
         m_owner = 0;
         m_last  = 2;
         m_sel   = 2'b00;
         return;
      end
      if (m_owner == 0) begin
         if (hreq_1 && hreq_2)   nxt = 3 - m_last;
         else if (hreq_1)        nxt = 1;
         else if (hreq_2)        nxt = 2;
      end else if (hready || hready_out) begin
         if (wants(3 - m_owner))                nxt = 3 - m_owner;
         else if (hresp || !wants(m_owner))     nxt = 0;
      end
      m_owner = nxt;
      if (nxt != 0) m_last = nxt;
      m_sel = (nxt == 1) ? sel_1 : (nxt == 2) ? sel_2 : 2'b00;
   endtask

   task automatic compare(string name);
      logic       e1, e2;
      e1 = (m_owner == 1);
      e2 = (m_owner == 2);
      vectors++;
      if (hgrant_1 !== e1 || hgrant_2 !== e2 || sel !== m_sel) begin
         miscompares++;
         $display("FAIL %s: got g1=%b g2=%b sel=%b, want g1=%b g2=%b sel=%b",
                  name, hgrant_1, hgrant_2, sel, e1, e2, m_sel);
      end
   endtask

   task automatic lit(string name, logic g1, logic g2, logic [1:0] s);
      vectors++;
      if (hgrant_1 !== g1 || hgrant_2 !== g2 || sel !== s) begin
         miscompares++;
         $display("FAIL %s: got g1=%b g2=%b sel=%b, want g1=%b g2=%b sel=%b",
                  name, hgrant_1, hgrant_2, sel, g1, g2, s);
      end
   endtask

   task automatic step(string name, logic r, logic q1, logic q2, logic [1:0] s1,
                       logic [1:0] s2, logic rdy, logic rdyo, logic resp);
      hresetn = r; hreq_1 = q1; hreq_2 = q2; sel_1 = s1; sel_2 = s2;
      hready = rdy; hready_out = rdyo; hresp = resp;
      model_edge();
      @(posedge hclk);
      @(negedge hclk);
      compare(name);
   endtask

   initial begin
      hresetn = 1'b1; hreq_1 = 1'b0; hreq_2 = 1'b0; sel_1 = 2'b00; sel_2 = 2'b00;
      hready = 1'b0; hready_out = 1'b0; hresp = 1'b0;
      @(negedge hclk);

      step("reset", 1, 1, 1, 2'b11, 2'b10, 1, 1, 1);
      lit("reset_lit", 0, 0, 2'b00);
      step("req1_grant", 0, 1, 0, 2'b01, 2'b00, 0, 0, 0);
      lit("req1_grant_lit", 1, 0, 2'b01);
      for (int i = 0; i < 2; i++) begin
         step("hold_no_boundary", 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
         lit("hold_no_boundary_lit", 1, 0, 2'b01);
      end
      step("handover_2", 0, 0, 1, 2'b01, 2'b10, 0, 1, 0);
      lit("handover_2_lit", 0, 1, 2'b10);

      step("reset2", 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      step("tie_to_m1", 0, 1, 1, 2'b11, 2'b01, 0, 0, 0);
      lit("tie_to_m1_lit", 1, 0, 2'b11);
      step("alternate_m2", 0, 1, 1, 2'b11, 2'b01, 1, 0, 0);
      lit("alternate_m2_lit", 0, 1, 2'b01);

      step("error_release", 0, 0, 1, 2'b11, 2'b01, 0, 1, 1);
      lit("error_release_lit", 0, 0, 2'b00);
      step("regrant_m2", 0, 0, 1, 2'b00, 2'b10, 0, 0, 0);
      lit("regrant_m2_lit", 0, 1, 2'b10);
      step("error_no_boundary", 0, 0, 1, 2'b00, 2'b11, 0, 0, 1);
      lit("error_no_boundary_lit", 0, 1, 2'b11);

      for (int i = 0; i < 3000; i++) begin
         step("random", ($urandom_range(0, 99) < 2),
              1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 4) == 0));
         if (hgrant_1 && hgrant_2) begin
            miscompares++;
            $display("FAIL onehot: got g1=%b g2=%b, want at most one high", hgrant_1, hgrant_2);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Two-master AHB-style bus arbiter. Samples the request lines of master 1 and master 2 and issues one-hot registered grants. Routes the granted master's 2-bit slave select onto the shared `sel` output. Sits between the two masters and the address decoder/slave mux. Bus handover happens only at transfer boundaries, as signalled by the ready inputs.

Parameters:
None. Widths are fixed: select 2 bits, 2 masters.

Ports:
- hclk  input  1  bus clock; all state updates on rising edge.
- hresetn  input  1  synchronous reset, active-high (asserted when 1, sampled on rising hclk) despite the name.
- hreq_1  input  1  bus request from master 1.
- hreq_2  input  1  bus request from master 2.
- sel_1  input  2  slave select from master 1.
- sel_2  input  2  slave select from master 2.
- hready  input  1  bus-level transfer-complete indication.
- hready_out  input  1  ready returned by the currently selected slave.
- hresp  input  1  slave response; 1 = ERROR.
- hgrant_1  output  1  grant to master 1 (registered).
- hgrant_2  output  1  grant to master 2 (registered).
- sel  output  2  slave select of the granted master (registered).

Behaviour:
- Reset (hresetn=1 at a rising edge):
  - hgrant_1=0, hgrant_2=0, sel=2'b00.
  - State=IDLE, last_owner=master 2, so master 1 wins the first tie.
- States:
  - IDLE: no grant.
  - GNT1: hgrant_1=1.
  - GNT2: hgrant_2=1.
  - Grants are one-hot or zero; both high is never allowed.
- Boundary: boundary = hready | hready_out. No handover is permitted when boundary=0.
- IDLE transitions (bus idle, no boundary needed):
  - only hreq_1 -> GNT1.
  - only hreq_2 -> GNT2.
  - both -> the master that is not last_owner.
  - none -> stay IDLE.
- GNTx transitions, evaluated each edge:
  - boundary=0: hold the current grant regardless of requests or hresp.
  - boundary=1 and the owner still requests, other master idle: keep the grant.
  - boundary=1 and the other master requests: hand over to the other master (round-robin).
  - boundary=1 and neither requests: go to IDLE.
  - boundary=1, hresp=1, other master not requesting: go to IDLE (error forces release). If the other master requests, hand over to it.
- last_owner updates to the master entering a GNT state.
- Latency:
  - A request asserted before edge N, with the bus idle, gives a grant visible after edge N (1 cycle).
  - Release or handover takes effect one edge after the boundary is sampled.
- sel:
  - Each edge, sel takes sel_1 if the next state is GNT1, sel_2 if GNT2, 2'b00 if IDLE.
  - sel therefore tracks changes on the owner's select while the grant is held.
- Reset mid-operation: synchronously forces IDLE and zero outputs on that edge, overriding all other inputs.
- Unknown/X requests are not handled specially; the bench drives known values after reset.

Test Plan:
1. Reset: hresetn=1 for one edge, any inputs -> hgrant_1=0, hgrant_2=0, sel=00.
2. After reset, hreq_1=1, hreq_2=0, sel_1=01, hready=hready_out=0 -> next edge hgrant_1=1, sel=01.
3. Continuing from 2, hreq_1 drops, hready=hready_out=0 for 2 cycles -> hgrant_1 stays 1 (no boundary), sel=01.
4. Continuing, hreq_2=1, sel_2=10, hready_out=1, hresp=0 -> next edge hgrant_1=0, hgrant_2=1, sel=10.
5. From IDLE with hreq_1=hreq_2=1 simultaneously and last_owner=2 -> GNT1. After master 1 holds the grant and a boundary occurs with both requesting -> GNT2 (alternation).
6. In GNT2, hreq_1=0, hresp=1, hready_out=1 -> next edge IDLE, both grants 0, sel=00. Repeat with hresp=1, hready=hready_out=0 -> grant held.
